// File: rtl/tj_trig_pkg.sv
// rtl/tj_trig_pkg.sv - shared constants and helpers for the sequential trigger family
package tj_trig_pkg;

  localparam int MODE_STRICT = 0;
  localparam int MODE_LOOSE  = 1;

  // Register width for a value range of n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/masked_match.sv
// rtl/masked_match.sv - WIDTH-bit equality compare of data against a pattern under a mask
module masked_match #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [WIDTH-1:0] i_mask,
  output logic             o_match
);

  assign o_match = (((i_data ^ i_pattern) & i_mask) == '0);

endmodule

// File: rtl/seq_trigger_monitor.sv
// rtl/seq_trigger_monitor.sv - fires once a programmed sequence of masked patterns completes THRESHOLD times
module seq_trigger_monitor
  import tj_trig_pkg::*;
#(
  parameter int                     WIDTH     = 128,
  parameter int                     DEPTH     = 4,
  parameter logic [DEPTH*WIDTH-1:0] PATTERNS  = '0,
  parameter logic [WIDTH-1:0]       MASK      = '1,
  parameter int                     THRESHOLD = 1,
  parameter int                     MODE      = MODE_STRICT,
  parameter int                     STICKY    = 1,
  localparam int                    SW        = clog2_min1(DEPTH),
  localparam int                    CW        = clog2_min1(THRESHOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] state,
  input  logic             state_valid,
  output logic             trig,
  output logic [SW-1:0]    stage,
  output logic [CW-1:0]    seq_count
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(DEPTH - 1);
  localparam logic [CW-1:0] THRESH_CNT = CW'(THRESHOLD);
  localparam logic [CW-1:0] THRESH_M1  = CW'(THRESHOLD - 1);

  logic [SW-1:0]    r_stage;
  logic [CW-1:0]    r_seq_count;
  logic             r_trig;

  logic [SW-1:0]    w_stage_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_trig_nxt;
  logic [WIDTH-1:0] w_cur_pattern;
  logic             w_hit;
  logic             w_hit0;

  always_comb begin
    w_cur_pattern = PATTERNS[WIDTH-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      if (r_stage == SW'(i)) begin
        w_cur_pattern = PATTERNS[i*WIDTH +: WIDTH];
      end
    end
  end

  masked_match #(.WIDTH(WIDTH)) u_match_cur (
    .i_data    (state),
    .i_pattern (w_cur_pattern),
    .i_mask    (MASK),
    .o_match   (w_hit)
  );

  // Stage-0 compare lets strict mode restart at stage 1 on the missing sample.
  masked_match #(.WIDTH(WIDTH)) u_match_first (
    .i_data    (state),
    .i_pattern (PATTERNS[WIDTH-1:0]),
    .i_mask    (MASK),
    .o_match   (w_hit0)
  );

  always_comb begin
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_seq_count;
    w_trig_nxt  = (STICKY != 0) ? r_trig : 1'b0;
    if (clr) begin
      w_stage_nxt = '0;
      w_cnt_nxt   = '0;
      w_trig_nxt  = 1'b0;
    end else if (state_valid) begin
      if (w_hit) begin
        if (r_stage == LAST_STAGE) begin
          w_stage_nxt = '0;
          // A latched sticky trigger freezes the count at THRESHOLD.
          if (!((STICKY != 0) && r_trig)) begin
            if (r_seq_count < THRESH_M1) begin
              w_cnt_nxt = r_seq_count + 1'b1;
            end else begin
              w_trig_nxt = 1'b1;
              w_cnt_nxt  = (STICKY != 0) ? THRESH_CNT : '0;
            end
          end
        end else begin
          w_stage_nxt = r_stage + 1'b1;
        end
      end else if (MODE != MODE_LOOSE) begin
        w_stage_nxt = (w_hit0 && (DEPTH > 1)) ? SW'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage     <= '0;
      r_seq_count <= '0;
      r_trig      <= 1'b0;
    end else begin
      r_stage     <= w_stage_nxt;
      r_seq_count <= w_cnt_nxt;
      r_trig      <= w_trig_nxt;
    end
  end

  assign trig      = r_trig;
  assign stage     = r_stage;
  assign seq_count = r_seq_count;

endmodule

// File: tb/tb_seq_trigger_monitor.sv
// tb/tb_seq_trigger_monitor.sv - randomized and directed self-checking bench for seq_trigger_monitor
module tb_seq_trigger_monitor;

  localparam logic [23:0] PATS = 24'hC3B2A1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] state = 8'h00;
  logic       state_valid = 1'b0;

  logic       w_trig  [4];
  logic [1:0] w_stage [4];
  logic [1:0] w_cnt   [4];

  int n_cmp = 0;
  int n_err = 0;

  // Instance configs: 0 strict/sticky, 1 loose/sticky, 2 strict/pulse, 3 strict/sticky with mask F0.
  int         cfg_mode   [4] = '{0, 1, 0, 0};
  int         cfg_sticky [4] = '{1, 1, 0, 1};
  logic [7:0] cfg_mask   [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hF0};
  logic [7:0] pat        [3] = '{8'hA1, 8'hB2, 8'hC3};
  logic [7:0] pool       [8] = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'hA7, 8'hB0, 8'hCF, 8'h5A};

  int   m_stage [4];
  int   m_total [4];
  logic m_trig  [4];

  seq_trigger_monitor #(.WIDTH(8), .DEPTH(3), .PATTERNS(PATS), .MASK(8'hFF), .THRESHOLD(2), .MODE(0), .STICKY(1)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .state(state), .state_valid(state_valid),
    .trig(w_trig[0]), .stage(w_stage[0]), .seq_count(w_cnt[0]));
  seq_trigger_monitor #(.WIDTH(8), .DEPTH(3), .PATTERNS(PATS), .MASK(8'hFF), .THRESHOLD(2), .MODE(1), .STICKY(1)) u_l (
    .clk(clk), .rst(rst), .clr(clr), .state(state), .state_valid(state_valid),
    .trig(w_trig[1]), .stage(w_stage[1]), .seq_count(w_cnt[1]));
  seq_trigger_monitor #(.WIDTH(8), .DEPTH(3), .PATTERNS(PATS), .MASK(8'hFF), .THRESHOLD(2), .MODE(0), .STICKY(0)) u_p (
    .clk(clk), .rst(rst), .clr(clr), .state(state), .state_valid(state_valid),
    .trig(w_trig[2]), .stage(w_stage[2]), .seq_count(w_cnt[2]));
  seq_trigger_monitor #(.WIDTH(8), .DEPTH(3), .PATTERNS(PATS), .MASK(8'hF0), .THRESHOLD(2), .MODE(0), .STICKY(1)) u_m (
    .clk(clk), .rst(rst), .clr(clr), .state(state), .state_valid(state_valid),
    .trig(w_trig[3]), .stage(w_stage[3]), .seq_count(w_cnt[3]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_stage[i] = 0;
      m_total[i] = 0;
      m_trig[i]  = 1'b0;
    end
  endtask

  // Reference: track total completed sequences; count and trigger follow from that total.
  task automatic model_step(input bit c, input bit v, input logic [7:0] d);
    bit done;
    for (int i = 0; i < 4; i++) begin
      done = 1'b0;
      if (c) begin
        m_stage[i] = 0;
        m_total[i] = 0;
      end else if (v) begin
        if (((d ^ pat[m_stage[i]]) & cfg_mask[i]) == 8'h00) begin
          if (m_stage[i] == 2) begin
            m_stage[i] = 0;
            m_total[i]++;
            done = 1'b1;
          end else begin
            m_stage[i]++;
          end
        end else if (cfg_mode[i] == 0) begin
          m_stage[i] = (((d ^ pat[0]) & cfg_mask[i]) == 8'h00) ? 1 : 0;
        end
      end
      if (cfg_sticky[i] != 0) m_trig[i] = (m_total[i] >= 2);
      else                    m_trig[i] = done && (m_total[i] % 2 == 0);
    end
  endtask

  task automatic compare_all();
    int exp_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_cnt = (cfg_sticky[i] != 0) ? ((m_total[i] > 2) ? 2 : m_total[i]) : (m_total[i] % 2);
      check($sformatf("model_stage[%0d]", i), int'(w_stage[i]), m_stage[i]);
      check($sformatf("model_cnt[%0d]", i), int'(w_cnt[i]), exp_cnt);
      check($sformatf("model_trig[%0d]", i), int'(w_trig[i]), int'(m_trig[i]));
    end
  endtask

  task automatic cycle(input bit c, input bit v, input logic [7:0] d);
    clr = c;
    state_valid = v;
    state = d;
    @(posedge clk);
    #1;
    model_step(c, v, d);
    compare_all();
    clr = 1'b0;
    state_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
  endtask

  logic [7:0] seq_a [7] = '{8'hA1, 8'hB2, 8'h00, 8'hB2, 8'hA1, 8'hB2, 8'hA1};
  int         stg_a [7] = '{1, 2, 0, 0, 1, 2, 1};
  logic [7:0] seq_b [5] = '{8'hA1, 8'h00, 8'h00, 8'hB2, 8'hC3};
  int         stg_b [5] = '{1, 1, 1, 2, 0};
  logic [7:0] seq_m [3] = '{8'hA7, 8'hB0, 8'hCF};

  initial begin
    int r;
    logic [7:0] d;

    model_clear();
    do_reset();
    check("rst_trig", int'(w_trig[0]), 0);
    check("rst_stage", int'(w_stage[0]), 0);
    check("rst_cnt", int'(w_cnt[0]), 0);

    for (int k = 0; k < 3; k++) send(pat[k]);
    check("sticky_cnt1", int'(w_cnt[0]), 1);
    check("sticky_no_trig", int'(w_trig[0]), 0);
    for (int k = 0; k < 3; k++) send(pat[k]);
    check("sticky_fire", int'(w_trig[0]), 1);
    check("sticky_cnt_sat", int'(w_cnt[0]), 2);
    check("pulse_fire", int'(w_trig[2]), 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check("sticky_hold", int'(w_trig[0]), 1);
    end
    check("pulse_drop", int'(w_trig[2]), 0);

    do_reset();
    for (int k = 0; k < 7; k++) begin
      send(seq_a[k]);
      check($sformatf("strict_stage_%0d", k), int'(w_stage[0]), stg_a[k]);
    end

    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(seq_b[k]);
      check($sformatf("loose_stage_%0d", k), int'(w_stage[1]), stg_b[k]);
    end
    check("loose_cnt", int'(w_cnt[1]), 1);

    do_reset();
    for (int s = 1; s <= 4; s++) begin
      for (int k = 0; k < 3; k++) begin
        send(pat[k]);
        if (k < 2) check("pulse_low", int'(w_trig[2]), 0);
      end
      check($sformatf("pulse_cnt_seq%0d", s), int'(w_cnt[2]), s % 2);
      check($sformatf("pulse_trig_seq%0d", s), int'(w_trig[2]), (s % 2 == 0) ? 1 : 0);
    end

    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 3; k++) begin
        send(seq_m[k]);
        cycle(1'b0, 1'b0, seq_m[k]);
        check("mask_gap_stage", int'(w_stage[3]), (k + 1) % 3);
      end
    end
    check("mask_fire", int'(w_trig[3]), 1);

    do_reset();
    for (int k = 0; k < 5; k++) send(pat[k % 3]);
    check("pre_rst_stage", int'(w_stage[0]), 2);
    check("pre_rst_cnt", int'(w_cnt[0]), 1);
    rst = 1'b0;
    #1;
    check("async_rst_stage", int'(w_stage[0]), 0);
    check("async_rst_cnt", int'(w_cnt[0]), 0);
    check("async_rst_trig", int'(w_trig[0]), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) send(pat[k % 3]);
    cycle(1'b1, 1'b1, 8'hC3);
    check("clr_trig", int'(w_trig[0]), 0);
    check("clr_stage", int'(w_stage[0]), 0);
    check("clr_cnt", int'(w_cnt[0]), 0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      if (r < 2) do_reset();
      else       cycle(r < 5, $urandom_range(0, 3) != 0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_trigger_monitor.md
# seq_trigger_monitor

Parametrised sequential trigger for the cipher-wrapper benchmarks. It watches the plaintext bus entering the AES core and looks for a programmed sequence of DEPTH masked patterns. It asserts `trig` once that sequence has completed THRESHOLD times. It generalises the single-pattern combinational trigger with configurable width, sequence depth, repeat count, strict/loose matching mode and sticky/pulse output, so the team can generate many trigger variants for the detection dataset from one source.

## Interface
- `WIDTH`, 128: width of the monitored bus.
- `DEPTH`, 4: number of stages in the sequence; must be at least 1.
- `PATTERNS`, all zeros: DEPTH×WIDTH vector; stage i uses bits [i*WIDTH +: WIDTH].
- `MASK`, all ones: WIDTH bits; only bits set to 1 take part in the compare.
- `THRESHOLD`, 1: number of complete sequences needed to fire; must be at least 1.
- `MODE`, 0: 0 = strict (a mismatch restarts the sequence), 1 = loose (a mismatch holds the current stage).
- `STICKY`, 1: 1 = `trig` latches high until reset or `clr`; 0 = `trig` is a one-cycle pulse.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `clr`, input, 1: synchronous clear of all state.
- `state`, input, WIDTH: monitored plaintext.
- `state_valid`, input, 1: `state` is sampled only when this is high.
- `trig`, output, 1: trigger output, registered.
- `stage`, output, clog2(DEPTH) bits (minimum 1): current sequence position, registered.
- `seq_count`, output, clog2(THRESHOLD+1) bits: number of completed sequences, registered.

## Operation
- Reset (`rst`=0): `stage`=0, `seq_count`=0, `trig`=0, held for as long as reset is asserted.
- Match rule: `hit` = ((`state` ^ PATTERNS[stage]) & MASK) == 0, evaluated only when `state_valid`=1.
- Cycle with `state_valid`=0: all state holds; in pulse mode `trig` returns to 0.
- Cycle with `hit` and `stage` < DEPTH-1: `stage` increments.
- Cycle with `hit` and `stage` = DEPTH-1 (sequence complete):
  - `stage` returns to 0.
  - If `seq_count`+1 < THRESHOLD: `seq_count` increments.
  - Otherwise this is a fire event.
- Fire event, STICKY=1: `trig`=1 and `seq_count` saturates at THRESHOLD. While `trig`=1, further matching still advances `stage`, but `seq_count` does not change and `trig` stays 1.
- Fire event, STICKY=0: `trig`=1 for exactly one cycle and `seq_count` returns to 0, so the block re-arms and fires again every THRESHOLD sequences.
- Valid cycle with a miss, MODE=0: `stage` goes to 1 if `state` matches PATTERNS[0], otherwise to 0. Partial-overlap search beyond this is not required.
- Valid cycle with a miss, MODE=1: `stage` holds.
- DEPTH=1: every hit is a complete sequence; `stage` stays 0.
- `clr`=1: same effect as reset at the next edge. `clr` takes priority over `state_valid`.
- Reset asserted mid-sequence: all progress is lost immediately (asynchronous).
- `seq_count` never exceeds THRESHOLD, and never wraps.

## Timing
- Outputs are fully registered; there is no combinational path from `state` to `trig`.
- Latency: the valid cycle that completes the firing sequence at edge N produces `trig`=1 after edge N (visible from cycle N+1).
- Throughput: one sample per cycle; back-to-back valid cycles are allowed.
- Pulse mode: `trig` is high for exactly one cycle per fire event, even if the next sample is valid.

## Structure
- Shared package `tj_trig_pkg` holds:
  - the mode constants `MODE_STRICT`=0 and `MODE_LOOSE`=1;
  - a width helper that returns clog2 with a minimum of 1.
- One sub-module, `masked_match`: a parametrised WIDTH-bit compare of data against a pattern under a mask. It is instantiated twice: once for the current stage and once for stage 0 (the strict-mode restart check).
- Top level holds the stage register, the sequence counter and the `trig` register.

## Test plan
All scenarios use WIDTH=8, DEPTH=3, PATTERNS=C3,B2,A1 (stage 0 = A1, stage 1 = B2, stage 2 = C3), MASK=FF, THRESHOLD=2.
- STICKY=1, MODE=0; send valid A1,B2,C3,A1,B2,C3 → `seq_count` goes 0→1 after the first C3; `trig`=1 the cycle after the second C3 and stays 1 for 20 further idle cycles.
- MODE=0; send A1,B2,00,B2 → `stage` goes 1,2,0,0; send A1,B2,A1 → `stage` goes 1,2,1 (restart via stage-0 match).
- MODE=1; send A1,00,00,B2,C3 → `stage` goes 1,1,1,2,0; `seq_count`=1.
- STICKY=0; send 4 full sequences back-to-back → `trig` pulses exactly twice, one cycle each, after sequences 2 and 4; `seq_count` reads 1,0,1,0 after each sequence.
- With MASK=F0, send A7,B0,CF twice → fire event after the second CF; `state_valid`=0 gaps between samples leave `stage` unchanged.
- Pull `rst` low with `stage`=2 and `seq_count`=1 → all outputs go to 0 before the next clock edge. Assert `clr` together with a completing C3 → `trig` stays 0 and all state is 0.
